branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Back end of the branch predictor's training and recovery interface. It records every predicted branch at fetch (PC, predicted direction and target, GHR snapshot). It accepts execute-stage resolutions in any order and retires entries in program order. On retire it drives the predictor's `update_*`, `mispredict` and `recover_ghr` inputs, plus the fetch redirect, and flushes all younger entries on a misprediction.

## Interface
- `DEPTH`, 8, number of in-flight branch entries; power of two, ≥2
- `HISTORY_BITS`, 8, GHR width; must match the predictor
- `TAG_BITS`, $clog2(DEPTH), entry tag width (derived, not overridden)

- `clock`  in  1  single clock; all state on posedge
- `reset`  in  1  synchronous, active-low reset
- `alloc_valid`  in  1  fetch has a predicted branch to record
- `alloc_ready`  out  1  entry available; transfer when valid && ready
- `alloc_pc`  in  32  branch PC
- `alloc_pred_taken`  in  1  predictor direction
- `alloc_pred_target`  in  32  predictor target (PC+4 when not taken)
- `alloc_ghr`  in  HISTORY_BITS  GHR value used to index the PHT for this branch
- `alloc_tag`  out  TAG_BITS  tag given to the entry accepted this cycle (= tail index)
- `resolve_valid`  in  1  execute resolved a branch
- `resolve_tag`  in  TAG_BITS  entry being resolved
- `resolve_taken`  in  1  actual direction
- `resolve_target`  in  32  actual taken target
- `update_en`  out  1  one-cycle predictor training pulse
- `update_pc`, `update_target`  out  32  retired branch PC / actual target
- `update_taken`  out  1  actual direction
- `mispredict`  out  1  one-cycle recovery pulse; also flush to fetch/decode
- `recover_ghr`  out  HISTORY_BITS  GHR snapshot of the mispredicted branch
- `redirect_pc`  out  32  correct next PC: actual target if taken, else PC+4 (mod 2^32)

## Operation
- Circular buffer of DEPTH entries. Tracked with head pointer, tail pointer (TAG_BITS each, wrap DEPTH-1→0) and count (TAG_BITS+1).
- Per entry: `valid`, `resolved`, pc, pred_taken, pred_target, ghr, act_taken, act_target.
- Allocation: `alloc_ready = reset && count != DEPTH && !mispredict`. On transfer the tail entry is written with valid=1 and resolved=0, and tail increments. `alloc_tag` = tail, combinational.
- Resolution: if `resolve_valid` and the entry at `resolve_tag` is valid, write act_taken and act_target and set resolved=1. A resolve to an invalid entry is ignored. A second resolve to a resolved entry overwrites it.
- Retire: if the head entry is valid and resolved (registered state), it retires this cycle. Count decrements, head increments, and valid is cleared.
- Mismatch = (pred_taken != act_taken) || (act_taken && pred_target != act_target).
- Retire without mismatch: next cycle `update_en`=1 and `mispredict`=0.
- Retire with mismatch: next cycle `update_en`=1 and `mispredict`=1. At the retire edge every entry is invalidated, count=0, and tail=head+1 (=new head).
- `update_pc`, `update_taken`, `update_target`, `recover_ghr` and `redirect_pc` come from the retiring entry. They are registered and held until the next retire.
- Simultaneous events:
  - Alloc and non-mispredicting retire in the same cycle: both occur, count unchanged.
  - Alloc in the same cycle as a mispredicting retire: the alloc is accepted by handshake but discarded by the flush. Fetch must drop that branch, since it is on the wrong path.
  - Resolve to the head in the retire-check cycle: it takes effect one cycle later.
- `alloc_ready` ignores a same-cycle retire. A full queue stalls fetch for one cycle even if the head retires.

## Timing
- Reset (`reset`=0 at an edge): count=0, head=tail=0, all valid=0. `alloc_ready`=0 while reset is low and 1 on the first cycle after it.
- Outputs after reset: `update_en`=0, `mispredict`=0, `update_*`=0, `recover_ghr`=0, `redirect_pc`=0.
- Reset mid-operation discards all entries; no pending update or mispredict pulse is emitted.
- Latencies:
  - Resolve at edge E → retire eligible in the cycle after E.
  - Retire evaluated in cycle T → `update_en`/`mispredict` high in cycle T+1 for exactly one cycle.
  - Best-case alloc→update is 3 cycles: alloc edge, resolve edge, retire edge.
- At most one retire per cycle. `alloc_ready`=0 during the `mispredict` cycle.

## Test plan
- Reset, then alloc pc=0x100, pred_taken=1, target=0x200, ghr=0x5A; resolve taken, 0x200 → `update_en` one cycle: `update_pc`=0x100, `update_taken`=1, `mispredict`=0.
- Alloc tags 0,1,2; resolve in order 2,0,1 → three updates in PC order 0,1,2 on consecutive cycles, no mispredict.
- Alloc pc=0x40, pred_taken=0, ghr=0x0F; resolve taken target 0x80 → `mispredict`=1, `recover_ghr`=0x0F, `redirect_pc`=0x80. Younger entries flushed, count=0, `alloc_ready`=0 in that cycle and 1 the next.
- Pred taken 0x300, actual taken 0x304 → mispredict with `redirect_pc`=0x304. Pred taken, actual not-taken at pc=0xFFFFFFFC → `redirect_pc`=0x0.
- Fill DEPTH=8 entries without resolving → `alloc_ready`=0; tags wrap 7→0 after a retire. A resolve to a freed tag is ignored.
- Assert `reset`=0 with 5 entries pending and the head resolved → no `update_en` afterwards, `alloc_ready`=1, next `alloc_tag`=0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: records predicted branches at fetch, takes out-of-order
// resolutions, retires in program order and drives predictor training/recovery.
module branch_resolve_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned HISTORY_BITS = 8,
    localparam int unsigned TAG_BITS    = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [31:0]             alloc_pc,
    input  logic                    alloc_pred_taken,
    input  logic [31:0]             alloc_pred_target,
    input  logic [HISTORY_BITS-1:0] alloc_ghr,
    output logic [TAG_BITS-1:0]     alloc_tag,
    input  logic                    resolve_valid,
    input  logic [TAG_BITS-1:0]     resolve_tag,
    input  logic                    resolve_taken,
    input  logic [31:0]             resolve_target,
    output logic                    update_en,
    output logic [31:0]             update_pc,
    output logic [31:0]             update_target,
    output logic                    update_taken,
    output logic                    mispredict,
    output logic [HISTORY_BITS-1:0] recover_ghr,
    output logic [31:0]             redirect_pc
);

    localparam int unsigned CNT_BITS = TAG_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);

    logic [TAG_BITS-1:0]     head;
    logic [TAG_BITS-1:0]     tail;
    logic [CNT_BITS-1:0]     count;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_resolved;
    logic [DEPTH-1:0]        ent_pred_taken;
    logic [DEPTH-1:0]        ent_act_taken;
    logic [31:0]             ent_pc          [DEPTH];
    logic [31:0]             ent_pred_target [DEPTH];
    logic [31:0]             ent_act_target  [DEPTH];
    logic [HISTORY_BITS-1:0] ent_ghr         [DEPTH];

    logic                    alloc_fire;
    logic                    resolve_fire;
    logic                    retire_fire;
    logic                    retire_mismatch;
    logic [TAG_BITS-1:0]     head_next;

    // Handshake and retire decode from registered state only
    always_comb begin
        alloc_ready     = reset && (count != CNT_FULL) && !mispredict;
        alloc_tag       = tail;
        alloc_fire      = alloc_valid && alloc_ready;
        resolve_fire    = resolve_valid && ent_valid[resolve_tag];
        retire_fire     = ent_valid[head] && ent_resolved[head];
        retire_mismatch = (ent_pred_taken[head] != ent_act_taken[head]) ||
                          (ent_act_taken[head] && (ent_pred_target[head] != ent_act_target[head]));
        head_next       = head + TAG_BITS'(1);
    end

    // Pointers, occupancy and per-entry flags; a mispredicting retire flushes everything
    always_ff @(posedge clock) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_resolved <= '0;
        end else begin
            if (resolve_fire) begin
                ent_resolved[resolve_tag] <= 1'b1;
            end
            if (alloc_fire) begin
                ent_valid[tail]    <= 1'b1;
                ent_resolved[tail] <= 1'b0;
                tail               <= tail + TAG_BITS'(1);
            end
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
                head            <= head_next;
            end
            if (retire_fire && retire_mismatch) begin
                ent_valid <= '0;
                tail      <= head_next;
                count     <= '0;
            end else begin
                count <= count + CNT_BITS'(alloc_fire) - CNT_BITS'(retire_fire);
            end
        end
    end

    // Entry payload needs no reset: it is only read while the entry is valid
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            ent_pc[tail]          <= alloc_pc;
            ent_pred_taken[tail]  <= alloc_pred_taken;
            ent_pred_target[tail] <= alloc_pred_target;
            ent_ghr[tail]         <= alloc_ghr;
        end
        if (resolve_fire) begin
            ent_act_taken[resolve_tag]  <= resolve_taken;
            ent_act_target[resolve_tag] <= resolve_target;
        end
    end

    // Retire outputs: pulses last one cycle, payload holds until the next retire
    always_ff @(posedge clock) begin
        if (!reset) begin
            update_en     <= 1'b0;
            mispredict    <= 1'b0;
            update_pc     <= '0;
            update_target <= '0;
            update_taken  <= 1'b0;
            recover_ghr   <= '0;
            redirect_pc   <= '0;
        end else begin
            update_en  <= retire_fire;
            mispredict <= retire_fire && retire_mismatch;
            if (retire_fire) begin
                update_pc     <= ent_pc[head];
                update_target <= ent_act_target[head];
                update_taken  <= ent_act_taken[head];
                recover_ghr   <= ent_ghr[head];
                redirect_pc   <= ent_act_taken[head] ? ent_act_target[head]
                                                     : ent_pc[head] + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH        = 8;
    localparam int unsigned HISTORY_BITS = 8;
    localparam int unsigned TAG_BITS     = 3;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    alloc_valid = 1'b0;
    logic                    alloc_ready;
    logic [31:0]             alloc_pc = '0;
    logic                    alloc_pred_taken = 1'b0;
    logic [31:0]             alloc_pred_target = '0;
    logic [HISTORY_BITS-1:0] alloc_ghr = '0;
    logic [TAG_BITS-1:0]     alloc_tag;
    logic                    resolve_valid = 1'b0;
    logic [TAG_BITS-1:0]     resolve_tag = '0;
    logic                    resolve_taken = 1'b0;
    logic [31:0]             resolve_target = '0;
    logic                    update_en;
    logic [31:0]             update_pc;
    logic [31:0]             update_target;
    logic                    update_taken;
    logic                    mispredict;
    logic [HISTORY_BITS-1:0] recover_ghr;
    logic [31:0]             redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .HISTORY_BITS(HISTORY_BITS)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
        .alloc_ghr(alloc_ghr), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .mispredict(mispredict),
        .recover_ghr(recover_ghr), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic taken,
                             input logic [31:0] tgt, input logic [7:0] ghr);
        alloc_valid       = 1'b1;
        alloc_pc          = pc;
        alloc_pred_taken  = taken;
        alloc_pred_target = tgt;
        alloc_ghr         = ghr;
    endtask

    task automatic set_resolve(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
        resolve_valid  = 1'b1;
        resolve_tag    = tag;
        resolve_taken  = taken;
        resolve_target = tgt;
    endtask

    task automatic idle;
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b0;
        step();
        step();
        n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", alloc_ready); end
        n_cmp++; if (update_en !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b want 0/0", update_en, mispredict); end
        n_cmp++; if (update_pc !== 32'h0 || update_target !== 32'h0 || update_taken !== 1'b0) begin n_fail++; $display("FAIL reset_update_data: got %h/%h/%b want 0", update_pc, update_target, update_taken); end
        n_cmp++; if (recover_ghr !== 8'h0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_recover: got %h/%h want 0/0", recover_ghr, redirect_pc); end
        reset = 1'b1;
        #1;
        n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL reset_release: got ready=%b tag=%0d want 1/0", alloc_ready, alloc_tag); end
    endtask

    task automatic test_basic;
        do_reset();
        set_alloc(32'h100, 1'b1, 32'h200, 8'h5A);
        step();
        idle();
        set_resolve(3'd0, 1'b1, 32'h200);
        step();
        idle();
        n_cmp++; if (update_en !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", update_en); end
        step();
        n_cmp++; if (update_en !== 1'b1 || mispredict !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b/%b want 1/0", update_en, mispredict); end
        n_cmp++; if (update_pc !== 32'h100 || update_taken !== 1'b1 || update_target !== 32'h200) begin n_fail++; $display("FAIL basic_data: got %h/%b/%h want 100/1/200", update_pc, update_taken, update_target); end
        n_cmp++; if (redirect_pc !== 32'h200 || recover_ghr !== 8'h5A) begin n_fail++; $display("FAIL basic_redirect: got %h/%h want 200/5a", redirect_pc, recover_ghr); end
        step();
        n_cmp++; if (update_en !== 1'b0 || update_pc !== 32'h100) begin n_fail++; $display("FAIL basic_one_cycle: got %b/%h want 0/100", update_en, update_pc); end
    endtask

    task automatic test_out_of_order;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h20; exp_pc[2] = 32'h30;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(exp_pc[i], 1'b0, exp_pc[i] + 32'd4, 8'(i));
            n_cmp++; if (alloc_tag !== 3'(i) || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_tag%0d: got %0d/%b want %0d/1", i, alloc_tag, alloc_ready, i); end
            step();
        end
        idle();
        set_resolve(3'd2, 1'b0, 32'h34);
        step();
        set_resolve(3'd0, 1'b0, 32'h14);
        step();
        n_cmp++; if (update_en !== 1'b0) begin n_fail++; $display("FAIL ooo_no_early: got %b want 0", update_en); end
        set_resolve(3'd1, 1'b0, 32'h24);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (update_en !== 1'b1 || mispredict !== 1'b0 || update_pc !== exp_pc[i]) begin n_fail++; $display("FAIL ooo_retire%0d: got en=%b mp=%b pc=%h want 1/0/%h", i, update_en, mispredict, update_pc, exp_pc[i]); end
            step();
        end
        n_cmp++; if (update_en !== 1'b0) begin n_fail++; $display("FAIL ooo_done: got %b want 0", update_en); end
    endtask

    task automatic test_mispredict_flush;
        int pulses;
        do_reset();
        set_alloc(32'h40, 1'b0, 32'h44, 8'h0F);
        step();
        set_alloc(32'h44, 1'b0, 32'h48, 8'h1E);
        step();
        set_alloc(32'h48, 1'b0, 32'h4C, 8'h3C);
        step();
        idle();
        set_resolve(3'd0, 1'b1, 32'h80);
        step();
        set_resolve(3'd1, 1'b0, 32'h48);
        step();
        idle();
        n_cmp++; if (update_en !== 1'b1 || mispredict !== 1'b1) begin n_fail++; $display("FAIL mp_pulse: got %b/%b want 1/1", update_en, mispredict); end
        n_cmp++; if (recover_ghr !== 8'h0F || redirect_pc !== 32'h80 || update_taken !== 1'b1) begin n_fail++; $display("FAIL mp_data: got %h/%h/%b want 0f/80/1", recover_ghr, redirect_pc, update_taken); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL mp_ready_low: got %b want 0", alloc_ready); end
        step();
        n_cmp++; if (mispredict !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd1) begin n_fail++; $display("FAIL mp_after: got mp=%b ready=%b tag=%0d want 0/1/1", mispredict, alloc_ready, alloc_tag); end
        set_resolve(3'd2, 1'b0, 32'h4C);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            idle();
            if (update_en === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mp_flushed: got %0d updates want 0", pulses); end
    endtask

    task automatic test_target_cases;
        do_reset();
        set_alloc(32'h200, 1'b1, 32'h300, 8'h11);
        step();
        idle();
        set_resolve(3'd0, 1'b1, 32'h304);
        step();
        idle();
        step();
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h304 || update_target !== 32'h304) begin n_fail++; $display("FAIL tgt_wrong: got mp=%b redir=%h tgt=%h want 1/304/304", mispredict, redirect_pc, update_target); end
        step();
        set_alloc(32'hFFFF_FFFC, 1'b1, 32'h1000, 8'h22);
        n_cmp++; if (alloc_tag !== 3'd1) begin n_fail++; $display("FAIL tgt_newhead_tag: got %0d want 1", alloc_tag); end
        step();
        idle();
        set_resolve(3'd1, 1'b0, 32'h0);
        step();
        idle();
        step();
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0 || update_taken !== 1'b0 || recover_ghr !== 8'h22) begin n_fail++; $display("FAIL tgt_wrap: got mp=%b redir=%h tk=%b ghr=%h want 1/0/0/22", mispredict, redirect_pc, update_taken, recover_ghr); end
        step();
        set_alloc(32'h500, 1'b0, 32'h504, 8'h33);
        step();
        idle();
        set_resolve(3'd2, 1'b0, 32'h999);
        step();
        idle();
        step();
        n_cmp++; if (update_en !== 1'b1 || mispredict !== 1'b0 || redirect_pc !== 32'h504) begin n_fail++; $display("FAIL tgt_nt_ok: got en=%b mp=%b redir=%h want 1/0/504", update_en, mispredict, redirect_pc); end
    endtask

    task automatic test_full_wrap;
        int pulses;
        logic [31:0] last_pc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h1004 + 32'(i * 4), 8'(i));
            n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'(i)) begin n_fail++; $display("FAIL full_fill%0d: got ready=%b tag=%0d want 1/%0d", i, alloc_ready, alloc_tag, i); end
            step();
        end
        idle();
        n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", alloc_ready); end
        set_resolve(3'd0, 1'b0, 32'h1004);
        step();
        idle();
        n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall_on_retire: got %b want 0", alloc_ready); end
        step();
        n_cmp++; if (update_en !== 1'b1 || update_pc !== 32'h1000 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL full_wrap: got en=%b pc=%h ready=%b tag=%0d want 1/1000/1/0", update_en, update_pc, alloc_ready, alloc_tag); end
        set_resolve(3'd0, 1'b1, 32'h7777);
        step();
        idle();
        set_alloc(32'h2000, 1'b1, 32'h3000, 8'hAA);
        step();
        idle();
        n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_refill: got %b want 0", alloc_ready); end
        pulses = 0;
        last_pc = '0;
        for (int i = 1; i < 12; i++) begin
            if (i < 8) set_resolve(3'(i), 1'b0, 32'h1004 + 32'(i * 4));
            step();
            idle();
            if (update_en === 1'b1) begin pulses++; last_pc = update_pc; end
        end
        n_cmp++; if (pulses !== 7 || last_pc !== 32'h101C) begin n_fail++; $display("FAIL full_drain: got %0d updates last=%h want 7/101c", pulses, last_pc); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(32'h4000 + 32'(i * 4), 1'b0, 32'h4004 + 32'(i * 4), 8'h44);
            step();
        end
        idle();
        set_resolve(3'd0, 1'b0, 32'h4004);
        step();
        idle();
        reset = 1'b0;
        step();
        n_cmp++; if (alloc_ready !== 1'b0 || update_en !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset: got ready=%b en=%b want 0/0", alloc_ready, update_en); end
        reset = 1'b1;
        #1;
        n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL rmid_release: got ready=%b tag=%0d want 1/0", alloc_ready, alloc_tag); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (update_en === 1'b1 || mispredict === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_no_pulse: got %0d pulses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_mispredict_flush();
        test_target_cases();
        test_full_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
